varredura_matriz: RTL

Column-scan driver for the 5×7 LED panel.
- Consumes the 35 parallel pixel levels produced by the row registers (row r, column c) and time-multiplexes them onto a physical matrix.
- Scans one active-low column strobe at a time, with the five row lines carrying that column's pixels.
- Inserts a blanking gap between columns to suppress ghosting.
- Snapshots the pixel frame once per scan frame, so the message can change mid-scan without tearing.

---
 rtl/varredura_matriz.sv | 121 ++++++++++++
 1 files changed

// File: rtl/varredura_matriz.sv
// varredura_matriz -- column-scan driver for a 5x7 LED panel.
//
// Takes a 35-bit pixel frame and time-multiplexes it onto the panel. Only
// one column is lit at a time: each column is dark for BLANK cycles and then
// lit for DWELL cycles. The frame is copied into a local buffer once per
// scan, so a message can change mid-scan without tearing.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST_N      in   synchronous active-low reset
//   ENA        in   scan enable; low turns the panel dark
//   PIX[34:0]  in   pixel frame, bit (r-1)*7+(c-1) = row r, column c
//   COL_N[6:0] out  column strobes, active-low, at most one low
//   ROW[4:0]   out  row data for the strobed column, active-high
//   COL_IDX    out  current column counter, 0..6
//   FRAME_SYNC out  one-cycle pulse following each frame snapshot
module varredura_matriz #(
  parameter int unsigned DWELL = 5000,
  parameter int unsigned BLANK = 50
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENA,
  input  logic [34:0] PIX,
  output logic [6:0]  COL_N,
  output logic [4:0]  ROW,
  output logic [2:0]  COL_IDX,
  output logic        FRAME_SYNC
);

  localparam int unsigned MAXP = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  // The counter is loaded with N-1 and the phase ends when it reaches zero.
  // This gives exactly N cycles in the phase.
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    col_q;
  logic [34:0]   buf_q;
  logic          fs_q;
  logic [4:0]    row_bits;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      buf_q   <= '0;
      fs_q    <= 1'b0;
    end else if (!ENA) begin
      // Disable takes priority over every phase transition, including the
      // frame wrap, so no snapshot is taken on the edge where ENA drops.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_BLANK;
          cnt_q   <= BLANK_LD;
          col_q   <= '0;
          buf_q   <= PIX;
          fs_q    <= 1'b1;
        end
        S_BLANK: begin
          if (cnt_q == '0) begin
            state_q <= S_DRIVE;
            cnt_q   <= DWELL_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_q == '0) begin
            state_q <= S_BLANK;
            cnt_q   <= BLANK_LD;
            if (col_q == 3'd6) begin
              col_q <= '0;
              buf_q <= PIX;
              fs_q  <= 1'b1;
            end else begin
              col_q <= col_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pick out the five pixels of the current column from the buffer.
  for (genvar r = 0; r < 5; r++) begin : g_row
    assign row_bits[r] = buf_q[6'(r * 7) + {3'b000, col_q}];
  end

  always_comb begin
    COL_N = '1;
    ROW   = '0;
    if (state_q == S_DRIVE) begin
      COL_N = ~(7'd1 << col_q);
      ROW   = row_bits;
    end
  end

  assign COL_IDX    = col_q;
  assign FRAME_SYNC = fs_q;

endmodule
